// File: rtl/vga_palette_lut_if.sv
// Palette write bus for vga_palette_lut: request, address, {red,green,blue} data and ready.
interface vga_palette_lut_if #(
   parameter int IDX_W = 4,
   parameter int CH_W  = 4
) ();
   logic                wr_en;
   logic [IDX_W-1:0]    wr_addr;
   logic [3*CH_W-1:0]   wr_data;
   logic                wr_ready;

   modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vga_palette_lut.sv
// Writable colour palette with a 2-stage pixel pipeline and self-initialising grey ramp.
// Optional readback port enabled by defining VGA_PALETTE_READBACK_EN.
module vga_palette_lut #(
   parameter int IDX_W     = 4,
   parameter int CH_W      = 4,
   parameter bit SYNC_IDLE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  pix_idx,
   input  logic              pix_active,
   input  logic              hsync_in,
   input  logic              vsync_in,
   vga_palette_lut_if.slave  wr,
   output logic [CH_W-1:0]   red,
   output logic [CH_W-1:0]   green,
   output logic [CH_W-1:0]   blue,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              init_done
`ifdef VGA_PALETTE_READBACK_EN
   ,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [3*CH_W-1:0] rd_data
`endif
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int ENT_W = 3 * CH_W;

   typedef enum logic {INIT, RUN} state_t;

   state_t             state;
   logic [IDX_W-1:0]   init_cnt;
   logic [ENT_W-1:0]   pal [DEPTH];

   logic [ENT_W-1:0]   rd1;
   logic               act1;
   logic               hs1;
   logic               vs1;

   // Grey ramp: the index is repeated MSB-first until the channel is full.
   function automatic logic [ENT_W-1:0] default_entry(input logic [IDX_W-1:0] i);
      logic [CH_W-1:0] ch;
      ch = '0;
      for (int b = 0; b < CH_W; b++) begin
         ch[CH_W-1-b] = i[IDX_W-1-(b % IDX_W)];
      end
      return {ch, ch, ch};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= INIT;
         init_cnt    <= '0;
         init_done   <= 1'b0;
         wr.wr_ready <= 1'b0;
      end else if (state == INIT) begin
         if (init_cnt == IDX_W'(DEPTH-1)) begin
            state       <= RUN;
            init_done   <= 1'b1;
            wr.wr_ready <= 1'b1;
         end else begin
            init_cnt <= init_cnt + 1'b1;
         end
      end
   end

   // Initialisation owns the RAM until RUN; user writes are only possible once ready is high.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == INIT) begin
            pal[init_cnt] <= default_entry(init_cnt);
         end else if (wr.wr_en && wr.wr_ready) begin
            pal[wr.wr_addr] <= wr.wr_data;
         end
      end
   end

   // The RAM is read in stage 1 so a colliding write is seen only by later pixels.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd1       <= '0;
         act1      <= 1'b0;
         hs1       <= SYNC_IDLE;
         vs1       <= SYNC_IDLE;
         red       <= '0;
         green     <= '0;
         blue      <= '0;
         hsync_out <= SYNC_IDLE;
         vsync_out <= SYNC_IDLE;
      end else begin
         rd1       <= pal[pix_idx];
         act1      <= pix_active && (state == RUN);
         hs1       <= hsync_in;
         vs1       <= vsync_in;
         {red, green, blue} <= act1 ? rd1 : '0;
         hsync_out <= hs1;
         vsync_out <= vs1;
      end
   end

`ifdef VGA_PALETTE_READBACK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= (state == RUN) ? pal[rd_addr] : '0;
      end
   end
`endif

endmodule

// File: tb/tb_vga_palette_lut.sv
// Self-checking bench for vga_palette_lut: cycle model of the palette plus directed literal checks.
module tb_vga_palette_lut;

   localparam int IDX_W = 4;
   localparam int CH_W  = 4;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  pix_idx;
   logic        pix_active;
   logic        hsync_in;
   logic        vsync_in;
   logic [3:0]  red;
   logic [3:0]  green;
   logic [3:0]  blue;
   logic        hsync_out;
   logic        vsync_out;
   logic        init_done;
`ifdef VGA_PALETTE_READBACK_EN
   logic [3:0]  rd_addr;
   logic [11:0] rd_data;
`endif

   vga_palette_lut_if #(.IDX_W(IDX_W), .CH_W(CH_W)) wr ();

   vga_palette_lut #(.IDX_W(IDX_W), .CH_W(CH_W), .SYNC_IDLE(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .pix_idx    (pix_idx),
      .pix_active (pix_active),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .wr         (wr),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .init_done  (init_done)
`ifdef VGA_PALETTE_READBACK_EN
      ,
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference state: palette contents, init progress and what each pipeline stage holds.
   logic [11:0] mPal [DEPTH];
   int          mCnt   = 0;
   bit          mValid = 1'b0;
   bit          mRun;
   bit          mDone;
   logic [11:0] s1Col, s2Col, mRd;
   bit          s1Hs, s1Vs, s2Hs, s2Vs;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] idx, input logic act, input logic we,
                                input logic [3:0] wa, input logic [11:0] wd);
      pix_idx    = idx;
      pix_active = act;
      wr.wr_en   = we;
      wr.wr_addr = wa;
      wr.wr_data = wd;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Model updates on each rising edge from the inputs the DUT sees at that edge.
   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            for (int i = 0; i < DEPTH; i++) mPal[i] = 12'(i * 12'h111);
            mCnt  = 0;
            s1Col = '0; s2Col = '0; mRd = '0;
            s1Hs  = 1'b1; s1Vs = 1'b1; s2Hs = 1'b1; s2Vs = 1'b1;
            mDone = 1'b0;
            mValid = 1'b1;
         end else if (mValid) begin
            mRun  = (mCnt >= DEPTH);
            s2Col = s1Col; s2Hs = s1Hs; s2Vs = s1Vs;
            s1Col = (pix_active && mRun) ? mPal[pix_idx] : 12'h000;
            s1Hs  = hsync_in; s1Vs = vsync_in;
`ifdef VGA_PALETTE_READBACK_EN
            mRd   = mRun ? mPal[rd_addr] : 12'h000;
`endif
            if (wr.wr_en && mRun) mPal[wr.wr_addr] = wr.wr_data;
            if (!mRun) mCnt++;
            mDone = (mCnt >= DEPTH);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mValid) begin
            checkOutput("model_rgb", {red, green, blue}, s2Col);
            checkOutput("model_hsync", hsync_out, s2Hs);
            checkOutput("model_vsync", vsync_out, s2Vs);
            checkOutput("model_init_done", init_done, mDone);
            checkOutput("model_wr_ready", wr.wr_ready, mDone);
`ifdef VGA_PALETTE_READBACK_EN
            checkOutput("model_rd_data", rd_data, mRd);
`endif
         end
      end
   end

   bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      reset    = 1'b1;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
`ifdef VGA_PALETTE_READBACK_EN
      rd_addr  = 4'd0;
`endif
      applyStimulus(4'd0, 1'b0, 1'b0, 4'd0, 12'h000);
      step();
      checkOutput("rst_hsync", hsync_out, 1'b1);
      checkOutput("rst_vsync", vsync_out, 1'b1);
      checkOutput("rst_init_done", init_done, 1'b0);
      checkOutput("rst_wr_ready", wr.wr_ready, 1'b0);
      checkOutput("rst_rgb", {red, green, blue}, 12'h000);

      // Write to entry 0 held through the whole init window must be dropped.
      reset = 1'b0;
      applyStimulus(4'd0, 1'b0, 1'b1, 4'd0, 12'hFFF);
      for (int i = 0; i < 15; i++) begin
         step();
         checkOutput("init_done_low", init_done, 1'b0);
         checkOutput("init_wr_ready_low", wr.wr_ready, 1'b0);
      end
      step();
      checkOutput("init_done_rise", init_done, 1'b1);
      checkOutput("wr_ready_rise", wr.wr_ready, 1'b1);
      applyStimulus(4'd0, 1'b1, 1'b0, 4'd0, 12'h000);
      step(); step();
      checkOutput("idx0_after_init_write", {red, green, blue}, 12'h000);

      applyStimulus(4'hA, 1'b1, 1'b0, 4'd0, 12'h000);
      step(); step();
      checkOutput("idxA_active", {red, green, blue}, 12'hAAA);
      applyStimulus(4'hA, 1'b0, 1'b0, 4'd0, 12'h000);
      step(); step();
      checkOutput("idxA_blank", {red, green, blue}, 12'h000);

      applyStimulus(4'd2, 1'b1, 1'b1, 4'd3, 12'hF80);
      step();
      applyStimulus(4'd3, 1'b1, 1'b0, 4'd0, 12'h000);
      step();
      checkOutput("idx2_untouched", {red, green, blue}, 12'h222);
      step();
      checkOutput("idx3_written", {red, green, blue}, 12'hF80);

`ifdef VGA_PALETTE_READBACK_EN
      rd_addr = 4'd3;
      step();
      checkOutput("readback_3", rd_data, 12'hF80);
`endif

      applyStimulus(4'd5, 1'b1, 1'b1, 4'd5, 12'h0F0);
      step();
      applyStimulus(4'd5, 1'b1, 1'b0, 4'd0, 12'h000);
      step();
      checkOutput("collision_old", {red, green, blue}, 12'h555);
      step();
      checkOutput("collision_new", {red, green, blue}, 12'h0F0);

      applyStimulus(4'd1, 1'b1, 1'b1, 4'd1, 12'h123);
      step();
      applyStimulus(4'd1, 1'b1, 1'b0, 4'd0, 12'h000);
      step(); step();
      checkOutput("idx1_written", {red, green, blue}, 12'h123);
      reset = 1'b1;
      step();
      checkOutput("midreset_rgb", {red, green, blue}, 12'h000);
      checkOutput("midreset_hsync", hsync_out, 1'b1);
      checkOutput("midreset_init_done", init_done, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) step();
      step(); step();
      checkOutput("idx1_restored", {red, green, blue}, 12'h111);

      // Sync pattern straight after reset, while the palette is still initialising.
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int t = 0; t < 8; t++) begin
         if (t >= 2) checkOutput("hsync_pattern", hsync_out, pat[t-2]);
         if (t < 6) hsync_in = pat[t];
         step();
      end

      for (int i = 0; i < 3000; i++) begin
         applyStimulus(4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                       4'($urandom), 12'($urandom));
         hsync_in = 1'($urandom);
         vsync_in = 1'($urandom);
`ifdef VGA_PALETTE_READBACK_EN
         rd_addr  = 4'($urandom);
`endif
         reset    = ($urandom_range(0, 599) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
